// File: rtl/pc_update_unit.sv
// PC update stage of the multicycle MIPS datapath.
// Holds the program counter, applies unconditional / branch-conditional writes from the
// PC-source mux, and sequences exception entry: capture EPC and cause, fetch the handler
// address byte from the exception vector, then load it into PC.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned VEC_BASE    = 253,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_op,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic [2:0]  exc_req,
    input  logic [7:0]  mem_byte,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        exc_busy,
    output logic [31:0] vec_addr,
    output logic        vec_rd
);

    typedef enum logic [1:0] {
        StIdle,
        StSave,
        StWait,
        StLoad
    } state_t;

    localparam logic [1:0] CauseNone   = 2'b00;
    localparam logic [1:0] CauseOpcode = 2'b01;
    localparam logic [1:0] CauseOvf    = 2'b10;
    localparam logic [1:0] CauseDiv0   = 2'b11;

    localparam logic [31:0] VecBase = 32'(VEC_BASE);
    localparam logic [2:0]  WaitLoad = 3'(MEM_LATENCY);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic        cond;
    logic        pc_we;
    logic [1:0]  exc_cause;
    logic        exc_accept;
    logic [31:0] vec_target;

    // Branch condition decode from the ALU flags.
    always_comb begin
        cond = 1'b0;
        unique case (branch_op)
            2'b00:   cond = alu_zero;
            2'b01:   cond = !alu_zero;
            2'b10:   cond = alu_gt;
            2'b11:   cond = !alu_gt;
            default: cond = 1'b0;
        endcase
    end

    // Exception priority encode: opcode > overflow > divide-by-zero.
    always_comb begin
        exc_cause = CauseNone;
        if (exc_req[0]) begin
            exc_cause = CauseOpcode;
        end else if (exc_req[1]) begin
            exc_cause = CauseOvf;
        end else if (exc_req[2]) begin
            exc_cause = CauseDiv0;
        end
    end

    // Accept/write qualification and the vector address for the pending cause (253/254/255).
    always_comb begin
        exc_accept = (exc_req != 3'b000);
        pc_we      = pc_write || (pc_write_cond && cond);
        vec_target = VecBase + {30'b0, exc_cause} - 32'd1;
    end

    // Exception sequencer and PC register with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            wait_cnt <= 3'd0;
            pc       <= RESET_PC;
            epc      <= 32'd0;
            cause    <= CauseNone;
            exc_busy <= 1'b0;
            vec_addr <= 32'd0;
            vec_rd   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (exc_accept) begin
                        // The faulting instruction's PC is one word behind the fetched PC.
                        epc      <= pc - 32'd4;
                        cause    <= exc_cause;
                        exc_busy <= 1'b1;
                        // Raised here so the read request is already visible during SAVE.
                        vec_rd   <= 1'b1;
                        vec_addr <= vec_target;
                        state    <= StSave;
                    end else if (pc_we) begin
                        pc <= next_pc;
                    end
                end
                StSave: begin
                    wait_cnt <= WaitLoad;
                    state    <= StWait;
                end
                StWait: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    // A count of 0 is treated like 1 so a bad MEM_LATENCY cannot wrap.
                    if (wait_cnt <= 3'd1) begin
                        vec_rd   <= 1'b0;
                        vec_addr <= 32'd0;
                        state    <= StLoad;
                    end
                end
                StLoad: begin
                    pc       <= {24'b0, mem_byte};
                    exc_busy <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
